// File: rtl/stream_pacer.sv
// Stream pacer: buffers AXI-Stream beats in a 4-deep FIFO and replays them as
// samples at a fixed programmable rate, checking packet length against tlast.
module stream_pacer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [24:0] count,
  input  logic [15:0] rate_div,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [15:0] sample_data,
  output logic        sample_strobe,
  output logic        busy,
  output logic        done,
  output logic        err_early_tlast,
  output logic        err_missing_tlast,
  output logic        err_underrun
);

  typedef enum logic [1:0] {IDLE, RUNNING, FLUSH, DRAIN} state_t;

  state_t      state;
  logic [24:0] count_q;
  logic [24:0] rx_count;
  logic [15:0] rate_q;
  logic [15:0] divider;
  logic [15:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  occ;

  logic        accept;
  logic        tick;
  logic        push;
  logic        pop;
  logic        start_ok;
  logic [2:0]  occ_next;
  logic [24:0] rx_inc;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign tick     = (state != IDLE) && (divider == rate_q);
  assign push     = accept && (state == RUNNING);
  // Pops look only at registered occupancy, so a beat pushed this cycle
  // cannot be replayed until the next tick.
  assign pop      = tick && (occ != 3'd0);
  assign occ_next = occ + {2'b00, push} - {2'b00, pop};
  assign rx_inc   = rx_count + 25'd1;
  assign start_ok = (state == IDLE) && start && (count != 25'd0);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      count_q           <= '0;
      rate_q            <= '0;
      rx_count          <= '0;
      divider           <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      occ               <= '0;
      s_axis_tready     <= 1'b0;
      sample_data       <= '0;
      sample_strobe     <= 1'b0;
      done              <= 1'b0;
      err_early_tlast   <= 1'b0;
      err_missing_tlast <= 1'b0;
      err_underrun      <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      done          <= 1'b0;

      if (start_ok) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        occ     <= '0;
        divider <= '0;
      end else if (state != IDLE) begin
        occ     <= occ_next;
        divider <= tick ? 16'd0 : divider + 16'd1;
        if (push) begin
          wr_ptr <= wr_ptr + 2'd1;
        end
        if (pop) begin
          rd_ptr        <= rd_ptr + 2'd1;
          sample_data   <= fifo_mem[rd_ptr];
          sample_strobe <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          s_axis_tready <= 1'b0;
          if (start_ok) begin
            state             <= RUNNING;
            s_axis_tready     <= 1'b1;
            count_q           <= count;
            rate_q            <= rate_div;
            rx_count          <= '0;
            err_early_tlast   <= 1'b0;
            err_missing_tlast <= 1'b0;
            err_underrun      <= 1'b0;
          end
        end

        RUNNING: begin
          s_axis_tready <= (occ_next != 3'd4);
          if (tick && (occ == 3'd0)) begin
            err_underrun <= 1'b1;
          end
          if (accept) begin
            rx_count <= rx_inc;
            if (rx_inc == count_q) begin
              // Packet length reached: a missing tlast means the rest of the
              // packet must be swallowed before draining.
              s_axis_tready <= !s_axis_tlast;
              if (s_axis_tlast) begin
                state <= DRAIN;
              end else begin
                err_missing_tlast <= 1'b1;
                state             <= FLUSH;
              end
            end else if (s_axis_tlast) begin
              err_early_tlast <= 1'b1;
              s_axis_tready   <= 1'b0;
              state           <= DRAIN;
            end
          end
        end

        FLUSH: begin
          s_axis_tready <= !(accept && s_axis_tlast);
          if (accept && s_axis_tlast) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          s_axis_tready <= 1'b0;
          if (occ == 3'd0) begin
            done    <= 1'b1;
            divider <= '0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pacer.sv
// Bench for stream_pacer: a queue-based cycle model checks every output each
// cycle, with directed vectors, hand sequences and randomized packets on top.
module tb_stream_pacer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [24:0] count;
  logic [15:0] rate_div;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [15:0] sample_data;
  logic        sample_strobe;
  logic        busy;
  logic        done;
  logic        err_early_tlast;
  logic        err_missing_tlast;
  logic        err_underrun;

  stream_pacer dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .count            (count),
    .rate_div         (rate_div),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .sample_data      (sample_data),
    .sample_strobe    (sample_strobe),
    .busy             (busy),
    .done             (done),
    .err_early_tlast  (err_early_tlast),
    .err_missing_tlast(err_missing_tlast),
    .err_underrun     (err_underrun)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Behavioural model: phase 0 idle, 1 running, 2 flush, 3 drain.
  int          m_phase;
  int          m_n;
  int          m_r;
  int          m_rx;
  int          m_k;
  logic [15:0] m_q[$];
  logic        m_ready;
  logic        m_strobe;
  logic        m_done;
  logic [15:0] m_data;
  logic        m_early;
  logic        m_miss;
  logic        m_under;

  logic [15:0] beat_data [64];
  logic [15:0] obs[$];
  int          strobe_cycles[$];
  int          done_cycle;

  typedef struct {
    int         n;
    int         r;
    int         nb;
    int         tl;
    int         gap;
    bit         hold;
    int         exp_strobes;
    logic [2:0] exp_err;
    int         exp_space;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [22:0] act_vec();
    return {s_axis_tready, sample_strobe, busy, done,
            err_early_tlast, err_missing_tlast, err_underrun, sample_data};
  endfunction

  function automatic logic [22:0] exp_vec();
    return {m_ready, m_strobe, (m_phase != 0), m_done,
            m_early, m_miss, m_under, m_data};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_q.delete();
    m_ready  = 1'b0;
    m_strobe = 1'b0;
    m_done   = 1'b0;
    m_data   = '0;
    m_early  = 1'b0;
    m_miss   = 1'b0;
    m_under  = 1'b0;
    m_k      = 0;
    m_rx     = 0;
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step();
    bit acc;
    bit tick;
    int sz0;
    int nphase;
    acc      = s_axis_tvalid && m_ready;
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (m_phase == 0) begin
      m_ready = 1'b0;
      if (start && count != 25'd0) begin
        m_n     = int'(count);
        m_r     = int'(rate_div);
        m_rx    = 0;
        m_k     = 0;
        m_q.delete();
        m_early = 1'b0;
        m_miss  = 1'b0;
        m_under = 1'b0;
        m_phase = 1;
        m_ready = 1'b1;
      end
    end else begin
      sz0    = m_q.size();
      tick   = (m_k % (m_r + 1)) == m_r;
      nphase = m_phase;
      if (tick && sz0 > 0) begin
        m_data   = m_q.pop_front();
        m_strobe = 1'b1;
      end
      if (tick && sz0 == 0 && m_phase == 1) m_under = 1'b1;
      if (m_phase == 1 && acc) begin
        m_q.push_back(s_axis_tdata);
        m_rx++;
        if (m_rx == m_n) begin
          if (s_axis_tlast) nphase = 3;
          else begin
            m_miss = 1'b1;
            nphase = 2;
          end
        end else if (s_axis_tlast) begin
          m_early = 1'b1;
          nphase  = 3;
        end
      end
      if (m_phase == 2 && acc && s_axis_tlast) nphase = 3;
      if (m_phase == 3 && sz0 == 0) begin
        m_done = 1'b1;
        nphase = 0;
      end
      m_phase = nphase;
      m_k++;
      m_ready = (nphase == 1 && m_q.size() < 4) || nphase == 2;
    end
  endtask

  task automatic idle_cycles(input int k, input logic st, input logic [24:0] cnt);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      cyc++;
      check_output("outputs", 32'(act_vec()), 32'(exp_vec()));
      start         = st;
      count         = cnt;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      model_step();
    end
  endtask

  task automatic run_packet(input int n, input int r, input int nb, input int tl,
                            input int gap, input bit rnd_gap, input bit hold_start,
                            input int abort_after, output bit got_done);
    int b;
    int wait_ct;
    bit last_ready;
    obs.delete();
    strobe_cycles.delete();
    done_cycle = -1;
    got_done   = 1'b0;
    b          = 0;
    wait_ct    = 0;
    @(negedge clk);
    cyc++;
    check_output("outputs", 32'(act_vec()), 32'(exp_vec()));
    start         = 1'b1;
    count         = 25'(n);
    rate_div      = 16'(r);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    last_ready    = s_axis_tready;
    model_step();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cyc++;
      check_output("outputs", 32'(act_vec()), 32'(exp_vec()));
      if (s_axis_tvalid && last_ready) begin
        b++;
        wait_ct = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
      end
      if (sample_strobe) begin
        obs.push_back(sample_data);
        strobe_cycles.push_back(cyc);
      end
      if (done) begin
        got_done   = 1'b1;
        done_cycle = cyc;
      end
      start = hold_start && !got_done;
      if (hold_start) count = 25'($urandom_range(2, 1));
      last_ready = s_axis_tready;
      if (b < nb && wait_ct == 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat_data[b];
        s_axis_tlast  = (b + 1 == tl);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (wait_ct > 0) wait_ct--;
      end
      model_step();
      if (got_done || (abort_after > 0 && obs.size() >= abort_after)) break;
    end
    if (abort_after == 0) check_output("done seen", 32'(got_done), 32'd1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    bit gd;
    for (int i = 0; i < 64; i++) beat_data[i] = 16'(i + 1);
    run_packet(v.n, v.r, v.nb, v.tl, v.gap, 1'b0, v.hold, 0, gd);
    check_output("strobe count", 32'(obs.size()), 32'(v.exp_strobes));
    for (int i = 0; i < obs.size(); i++) begin
      check_output("sample order", 32'(obs[i]), 32'(i + 1));
    end
    check_output("error flags", 32'({err_early_tlast, err_missing_tlast, err_underrun}),
                 32'(v.exp_err));
    if (strobe_cycles.size() > 0) begin
      check_output("done after last strobe", 32'(done_cycle - strobe_cycles[$]), 32'd1);
    end
    if (v.exp_space > 0) begin
      for (int i = 1; i < strobe_cycles.size(); i++) begin
        check_output("strobe spacing", 32'(strobe_cycles[i] - strobe_cycles[i-1]),
                     32'(v.exp_space));
      end
    end
    idle_cycles(2, 1'b0, 25'd0);
  endtask

  initial begin
    bit          gd;
    int          n;
    int          r;
    int          nb;
    int          tl;
    int          exp_m;
    int          mode;
    logic [1:0]  exp_e;

    vecs = '{
      '{4,  2, 4,  4,  0, 1'b0, 4,  3'b000, 3},
      '{8,  2, 3,  3,  0, 1'b1, 3,  3'b100, 3},
      '{2,  2, 5,  5,  0, 1'b0, 2,  3'b010, 3},
      '{3,  0, 3,  3,  4, 1'b0, 3,  3'b001, 0},
      '{10, 9, 10, 10, 0, 1'b0, 10, 3'b000, 10},
      '{1,  1, 1,  1,  0, 1'b0, 1,  3'b000, 0},
      '{5,  3, 1,  1,  0, 1'b0, 1,  3'b100, 0}
    };

    resetn        = 1'b0;
    start         = 1'b0;
    count         = '0;
    rate_div      = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_output("reset outputs", 32'(act_vec()), 32'd0);
    resetn = 1'b1;
    model_step();

    // A start with zero length must leave the block idle.
    idle_cycles(3, 1'b1, 25'd0);
    idle_cycles(1, 1'b0, 25'd0);
    check_output("count0 start ignored", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

    // Reset in the middle of a run, then a clean rerun.
    for (int i = 0; i < 64; i++) beat_data[i] = 16'(i + 1);
    run_packet(6, 2, 6, 6, 0, 1'b0, 1'b0, 2, gd);
    check_output("no done before reset", 32'(gd), 32'd0);
    check_output("busy before reset", 32'(busy), 32'd1);
    #2;
    resetn        = 1'b0;
    start         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #1;
    check_output("async reset outputs", 32'(act_vec()), 32'd0);
    model_reset();
    @(negedge clk);
    cyc++;
    check_output("outputs", 32'(act_vec()), 32'(exp_vec()));
    resetn = 1'b1;
    model_step();
    idle_cycles(3, 1'b0, 25'd0);
    apply_stimulus(vecs[0]);

    for (int t = 0; t < 40; t++) begin
      n    = int'($urandom_range(8, 1));
      r    = int'($urandom_range(3, 0));
      mode = int'($urandom_range(2, 0));
      if (mode == 1 && n > 1) begin
        tl    = int'($urandom_range(n - 1, 1));
        nb    = tl;
        exp_m = tl;
        exp_e = 2'b10;
      end else if (mode == 2) begin
        nb    = n + int'($urandom_range(3, 1));
        tl    = nb;
        exp_m = n;
        exp_e = 2'b01;
      end else begin
        nb    = n;
        tl    = n;
        exp_m = n;
        exp_e = 2'b00;
      end
      for (int i = 0; i < 64; i++) beat_data[i] = 16'($urandom);
      run_packet(n, r, nb, tl, 3, 1'b1, 1'b0, 0, gd);
      check_output("rand strobe count", 32'(obs.size()), 32'(exp_m));
      for (int i = 0; i < obs.size() && i < exp_m; i++) begin
        check_output("rand sample", 32'(obs[i]), 32'(beat_data[i]));
      end
      check_output("rand tlast flags", 32'({err_early_tlast, err_missing_tlast}), 32'(exp_e));
      idle_cycles(int'($urandom_range(2, 0)), 1'b0, 25'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stream_pacer.md
STREAM_PACER -- requirements
Module: stream_pacer

Interface
REQ-001 clk  input  1  single clock for the AXI-Stream interface and all logic; all registers update on its rising edge.
REQ-002 resetn  input  1  reset, asynchronous and active-low.
REQ-003 start  input  1  level, sampled in IDLE only; begins a packet run.
REQ-004 count  input  25  expected beats per packet; latched when start is accepted.
REQ-005 rate_div  input  16  output period minus one, in clk cycles; latched when start is accepted.
REQ-006 s_axis_tdata  input  16  slave AXI-Stream data (from DMA MM2S).
REQ-007 s_axis_tvalid  input  1  slave valid.
REQ-008 s_axis_tlast  input  1  slave end-of-packet.
REQ-009 s_axis_tready  output  1  slave ready, registered.
REQ-010 sample_data  output  16  paced sample; holds its value between strobes.
REQ-011 sample_strobe  output  1  one-cycle pulse; sample_data is new in that cycle.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse at run completion.
REQ-014 err_early_tlast, err_missing_tlast, err_underrun  output  1 each  sticky flags, cleared when start is accepted.

Function
REQ-015 A beat is accepted only when s_axis_tvalid and s_axis_tready are both high in the same cycle.
REQ-016 Accepted beats enter a 4-entry FIFO in order; no beat is dropped or reordered, except in FLUSH.
REQ-017 The state machine has states IDLE, RUNNING, FLUSH and DRAIN.
REQ-018 IDLE: s_axis_tready=0.
REQ-019 IDLE exit: start=1 and count!=0 moves to RUNNING; start with count==0 is ignored.
REQ-020 On accepting start, the block latches count and rate_div, clears rx_count, divider, FIFO and error flags.
REQ-021 RUNNING: s_axis_tready = FIFO not full; fullness uses registered occupancy, so no push occurs while full even if a pop happens in the same cycle.
REQ-022 RUNNING: each accepted beat increments the 25-bit rx_count.
REQ-023 Accepted beat with tlast=1 and rx_count+1 < count: err_early_tlast=1, move to DRAIN.
REQ-024 Accepted beat with rx_count+1 == count and tlast=1: move to DRAIN.
REQ-025 Accepted beat with rx_count+1 == count and tlast=0: err_missing_tlast=1, move to FLUSH.
REQ-026 FLUSH: s_axis_tready=1; accepted beats are discarded (not pushed); the first accepted tlast beat moves to DRAIN.
REQ-027 DRAIN: s_axis_tready=0.
REQ-028 Pacing: the divider runs from 0 to the latched rate_div in every non-IDLE state; tick occurs at rate_div, then the divider returns to 0.
REQ-029 First tick occurs rate_div+1 cycles after entering RUNNING.
REQ-030 Tick with FIFO non-empty pops one entry; sample_data takes the popped value and sample_strobe=1 in the next cycle (1-cycle latency).
REQ-031 Tick with FIFO empty in RUNNING sets err_underrun and produces no strobe.
REQ-032 Tick with FIFO empty in FLUSH or DRAIN is not an error.
REQ-033 DRAIN with FIFO empty and no pop pending: done=1 for one cycle, move to IDLE.
REQ-034 A same-cycle push and pop leaves occupancy unchanged.
REQ-035 start is ignored while busy.

Reset
REQ-036 resetn=0 asynchronously forces state=IDLE, FIFO empty, rx_count=0, divider=0.
REQ-037 During and after reset: s_axis_tready=0, sample_data=0, sample_strobe=0, busy=0, done=0, all error flags 0.
REQ-038 Reset mid-run abandons the packet; no done pulse is produced.

Verification
REQ-039 count=4, rate_div=2, beats 0x0001..0x0004 back-to-back, tlast on the 4th -> strobes every 3 cycles carrying 1,2,3,4; done one cycle after the last strobe; all error flags 0.
REQ-040 count=8, tlast on beat 3 -> err_early_tlast=1; exactly 3 strobes; done; tready=0 after beat 3.
REQ-041 count=2, tlast on beat 5 -> err_missing_tlast=1; beats 3-5 accepted and discarded; exactly 2 strobes (beats 1,2); done.
REQ-042 count=3, rate_div=0, one beat every 5 cycles -> err_underrun=1; all 3 samples output in order; done.
REQ-043 count=10, rate_div=9, tvalid held high -> tready low whenever the FIFO holds 4; all 10 values output in order; no errors.
REQ-044 resetn pulsed low mid-run after 2 strobes -> all outputs at reset values immediately; no done; a fresh start afterwards runs cleanly.
